// File: rtl/syn_av_mm_slave_regs_if.sv
// Avalon-MM register-access bus between a system master and a register slave.
// Request side: av_read/av_write qualify av_addr and av_write_data. Every cycle
// with either strobe high is a completed transfer (no waitrequest). Response
// side: av_read_data is meaningful only in cycles where av_rd_data_valid is high.
interface syn_av_mm_slave_regs_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              av_read;
    logic              av_write;
    logic [ADDR_W-1:0] av_addr;
    logic [DATA_W-1:0] av_write_data;
    logic [DATA_W-1:0] av_read_data;
    logic              av_rd_data_valid;

    modport master (
        output av_read, av_write, av_addr, av_write_data,
        input  av_read_data, av_rd_data_valid
    );

    modport slave (
        input  av_read, av_write, av_addr, av_write_data,
        output av_read_data, av_rd_data_valid
    );
endinterface

// File: rtl/syn_av_mm_slave_regs.sv
// Avalon-MM register-map slave: read-only ID at address 0, writable control
// registers at 1..NUM_REGS-1, fixed-latency pipelined read responses, per-register
// write pulses and a sticky flag for simultaneous read/write requests.
module syn_av_mm_slave_regs #(
    parameter int                ADDR_W        = 12,
    parameter int                DATA_W        = 16,
    parameter int                NUM_REGS      = 16,
    parameter int                RD_LATENCY    = 2,
    parameter logic [DATA_W-1:0] ID_VAL        = 16'h5E01,
    parameter logic [DATA_W-1:0] UNMAPPED_DATA = 16'hDEAD
) (
    input  logic                       av_clk,
    input  logic                       av_rst,
    syn_av_mm_slave_regs_if.slave      bus,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        reg_wr_pulse_o,
    output logic                       proto_err_o
);

    // Address 0 is a constant, so storage only exists for 1..NUM_REGS-1.
    logic [DATA_W-1:0] reg_q [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] wr_hit;
    logic [DATA_W-1:0]   rd_mux;

    logic [RD_LATENCY-1:0] vld_pipe;
    logic [DATA_W-1:0]     dat_pipe [RD_LATENCY];

    // Decode which writable register the current address selects (full compare, no aliasing).
    always_comb begin
        wr_hit = '0;
        for (int n = 1; n < NUM_REGS; n++) begin
            if (bus.av_addr == ADDR_W'(n)) wr_hit[n] = 1'b1;
        end
    end

    // Read data as seen before this cycle's edge: ID, register contents, or filler for unmapped.
    always_comb begin
        rd_mux = UNMAPPED_DATA;
        if (bus.av_addr == '0) rd_mux = ID_VAL;
        for (int n = 1; n < NUM_REGS; n++) begin
            if (bus.av_addr == ADDR_W'(n)) rd_mux = reg_q[n];
        end
    end

    // Register bank update; writes to address 0 or unmapped space never hit.
    always_ff @(posedge av_clk) begin
        if (av_rst) begin
            for (int n = 1; n < NUM_REGS; n++) reg_q[n] <= '0;
        end else if (bus.av_write) begin
            for (int n = 1; n < NUM_REGS; n++) begin
                if (wr_hit[n]) reg_q[n] <= bus.av_write_data;
            end
        end
    end

    // One-cycle write strobe for the register that was just written.
    always_ff @(posedge av_clk) begin
        if (av_rst) reg_wr_pulse_o <= '0;
        else        reg_wr_pulse_o <= bus.av_write ? wr_hit : '0;
    end

    // Sticky protocol error: read and write requested together.
    always_ff @(posedge av_clk) begin
        if (av_rst)                          proto_err_o <= 1'b0;
        else if (bus.av_read && bus.av_write) proto_err_o <= 1'b1;
    end

    // Read response shift pipeline; idle slots carry zero data so the output bus rests at 0.
    always_ff @(posedge av_clk) begin
        if (av_rst) begin
            vld_pipe <= '0;
            for (int k = 0; k < RD_LATENCY; k++) dat_pipe[k] <= '0;
        end else begin
            vld_pipe[0] <= bus.av_read;
            dat_pipe[0] <= bus.av_read ? rd_mux : '0;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign bus.av_rd_data_valid = vld_pipe[RD_LATENCY-1];
    assign bus.av_read_data     = dat_pipe[RD_LATENCY-1];

    // Flattened register view; slice 0 is the fixed ID.
    always_comb begin
        regs_o = '0;
        regs_o[0 +: DATA_W] = ID_VAL;
        for (int n = 1; n < NUM_REGS; n++) regs_o[n*DATA_W +: DATA_W] = reg_q[n];
    end

endmodule

// File: tb/tb_syn_av_mm_slave_regs.sv
// Bench for syn_av_mm_slave_regs: directed scenarios followed by random traffic,
// reference register-map model, expected-response queue and negedge monitor.
module tb_syn_av_mm_slave_regs;
    localparam int          AW    = 12;
    localparam int          DW    = 16;
    localparam int          NR    = 16;
    localparam int          LAT   = 2;
    localparam logic [15:0] ID    = 16'h5E01;
    localparam logic [15:0] UNMAP = 16'hDEAD;

    // ---------------- clock / reset ----------------
    logic av_clk = 1'b0;
    logic av_rst = 1'b1;
    always #5 av_clk = ~av_clk;

    syn_av_mm_slave_regs_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [NR*DW-1:0] regs_o;
    logic [NR-1:0]    reg_wr_pulse_o;
    logic             proto_err_o;

    syn_av_mm_slave_regs #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .RD_LATENCY(LAT),
        .ID_VAL(ID), .UNMAPPED_DATA(UNMAP)
    ) dut (
        .av_clk(av_clk), .av_rst(av_rst), .bus(bus.slave),
        .regs_o(regs_o), .reg_wr_pulse_o(reg_wr_pulse_o), .proto_err_o(proto_err_o)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] mdl [NR];
    logic [NR-1:0] exp_pulse;
    logic          exp_perr;
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            cyc = 0;
    bit            started = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (a == 0)       return ID;
        else if (a < NR)  return mdl[a];
        else              return UNMAP;
    endfunction

    function automatic logic [NR*DW-1:0] ref_regs();
        logic [NR*DW-1:0] v;
        v = '0;
        v[0 +: DW] = ID;
        for (int n = 1; n < NR; n++) v[n*DW +: DW] = mdl[n];
        return v;
    endfunction

    // ---------------- driver ----------------
    // Present one cycle of request, then apply the model's view of the clock edge.
    task automatic drive(input logic rd, input logic wr, input logic rst,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.av_read       = rd;
        bus.av_write      = wr;
        bus.av_addr       = addr;
        bus.av_write_data = data;
        av_rst            = rst;
        @(posedge av_clk);
        if (rst) begin
            for (int n = 0; n < NR; n++) mdl[n] = '0;
            exp_pulse = '0;
            exp_perr  = 1'b0;
            exp_q.delete();
            exp_cyc_q.delete();
            started = 1;
        end else begin
            exp_pulse = '0;
            if (rd) begin
                exp_q.push_back(ref_read(addr));
                exp_cyc_q.push_back(cyc + LAT);
            end
            if (wr && addr >= 1 && addr < NR) begin
                mdl[addr] = data;
                exp_pulse[addr] = 1'b1;
            end
            if (rd && wr) exp_perr = 1'b1;
        end
        cyc++;
        #1;
    endtask

    // Idle cycle with random address/data to show they are ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 1'b0, AW'($urandom), DW'($urandom));
    endtask

    task automatic rd(input int a);
        drive(1'b1, 1'b0, 1'b0, AW'(a), DW'($urandom));
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        drive(1'b0, 1'b1, 1'b0, AW'(a), d);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [DW-1:0] d;
        int            c;
        forever begin
            @(negedge av_clk);
            if (started) begin
                n_cmp++;
                if (regs_o !== ref_regs()) begin
                    n_err++;
                    $display("FAIL regs_o cyc=%0d got=%h exp=%h", cyc, regs_o, ref_regs());
                end
                n_cmp++;
                if (reg_wr_pulse_o !== exp_pulse) begin
                    n_err++;
                    $display("FAIL wr_pulse cyc=%0d got=%h exp=%h", cyc, reg_wr_pulse_o, exp_pulse);
                end
                n_cmp++;
                if (proto_err_o !== exp_perr) begin
                    n_err++;
                    $display("FAIL proto_err cyc=%0d got=%b exp=%b", cyc, proto_err_o, exp_perr);
                end
                if (bus.av_rd_data_valid === 1'b1) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rd_spurious cyc=%0d got data=%h exp no response", cyc, bus.av_read_data);
                    end else begin
                        d = exp_q.pop_front();
                        c = exp_cyc_q.pop_front();
                        if (bus.av_read_data !== d || c != cyc) begin
                            n_err++;
                            $display("FAIL rd_data cyc=%0d got=%h exp=%h exp_cyc=%0d", cyc, bus.av_read_data, d, c);
                        end
                    end
                end else begin
                    n_cmp++;
                    if (bus.av_rd_data_valid !== 1'b0 || bus.av_read_data !== '0) begin
                        n_err++;
                        $display("FAIL rd_idle cyc=%0d got valid=%b data=%h exp valid=0 data=0", cyc, bus.av_rd_data_valid, bus.av_read_data);
                    end
                    if (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
                        n_err++;
                        d = exp_q.pop_front();
                        c = exp_cyc_q.pop_front();
                        $display("FAIL rd_missing cyc=%0d got no valid exp=%h at cyc %0d", cyc, d, c);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        logic [AW-1:0] a;
        bus.av_read = 0; bus.av_write = 0; bus.av_addr = '0; bus.av_write_data = '0;
        @(posedge av_clk); #1;
        drive(0, 0, 1, '0, '0);
        drive(0, 0, 1, '0, '0);
        idle(2);

        // ID and reset-value reads
        rd(0); rd(5); idle(4);
        // write then read-after-write
        wr(3, 16'hA5A5); rd(3); idle(4);
        // dropped writes, unmapped and ID reads
        wr(0, 16'h1234); wr(16, 16'h1234); rd(16); rd(0); idle(4);
        // preload then back-to-back reads
        for (int n = 1; n <= 7; n++) wr(n, DW'(n * 16'h0101));
        for (int n = 1; n <= 7; n++) rd(n);
        rd(1); idle(4);
        // simultaneous read and write
        wr(2, 16'h0001);
        drive(1, 1, 0, AW'(2), 16'h00FF);
        idle(6);
        // reset with reads in flight and a read in the reset cycle
        rd(3);
        drive(1, 0, 1, AW'(4), '0);
        idle(4);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            a = ($urandom_range(0, 9) < 8) ? AW'($urandom_range(0, NR + 1)) : AW'($urandom);
            if ($urandom_range(0, 299) == 0)
                drive(r[0], r[1], 1, a, DW'($urandom));
            else if (r < 35)      drive(1, 0, 0, a, DW'($urandom));
            else if (r < 70)      drive(0, 1, 0, a, DW'($urandom));
            else if (r < 73)      drive(1, 1, 0, a, DW'($urandom));
            else                  drive(0, 0, 0, a, DW'($urandom));
        end
        idle(LAT + 3);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d outstanding exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
